// File: rtl/bus_arbiter_if.sv
// Signal bundle joining the two masters, the arbiter and the decoder/slave side.
// Pure wiring, no latency.
// No backpressure; a master holds req until its grant rises.
interface bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // Master 0 (system/testbench)
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_dout;
  logic              m0_grant;
  // Master 1 (auxiliary/DMA)
  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_dout;
  logic              m1_grant;
  // Granted master toward decoder and slaves
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  // Decoder selects and slave read data
  logic              s0_sel;
  logic              s1_sel;
  logic [DATA_W-1:0] s0_dout;
  logic [DATA_W-1:0] s1_dout;
  logic [DATA_W-1:0] m_din;

  // Arbiter view: it serves the masters and the slave return path
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_dout,
    input  m1_req, m1_wr, m1_addr, m1_dout,
    input  s0_sel, s1_sel, s0_dout, s1_dout,
    output m0_grant, m1_grant,
    output m_req, m_wr, m_addr, m_dout, m_din
  );

  // Environment view: masters, decoder and slaves
  modport master (
    output m0_req, m0_wr, m0_addr, m0_dout,
    output m1_req, m1_wr, m1_addr, m1_dout,
    output s0_sel, s1_sel, s0_dout, s1_dout,
    input  m0_grant, m1_grant,
    input  m_req, m_wr, m_addr, m_dout, m_din
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (M0 wins ties, no preemption) plus slave read-data return mux.
// Grant 1 cycle after request; bus mux combinational from grant; m_din 1 cycle after select.
// No backpressure; a master waits with req held while its grant is low.
module bus_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    M0_GNT = 2'd1,
    M1_GNT = 2'd2
  } state_t;

  state_t     state;
  logic       m0_grant_q;
  logic       m1_grant_q;
  logic [1:0] sel_q;

  // Arbitration: owner keeps the bus while requesting, handover to the other requester without an idle cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      m0_grant_q <= 1'b0;
      m1_grant_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req) begin
            state <= M0_GNT; m0_grant_q <= 1'b1; m1_grant_q <= 1'b0;
          end else if (bus.m1_req) begin
            state <= M1_GNT; m0_grant_q <= 1'b0; m1_grant_q <= 1'b1;
          end else begin
            state <= IDLE;   m0_grant_q <= 1'b0; m1_grant_q <= 1'b0;
          end
        end
        M0_GNT: begin
          if (bus.m0_req) begin
            state <= M0_GNT; m0_grant_q <= 1'b1; m1_grant_q <= 1'b0;
          end else if (bus.m1_req) begin
            state <= M1_GNT; m0_grant_q <= 1'b0; m1_grant_q <= 1'b1;
          end else begin
            state <= IDLE;   m0_grant_q <= 1'b0; m1_grant_q <= 1'b0;
          end
        end
        M1_GNT: begin
          if (bus.m1_req) begin
            state <= M1_GNT; m0_grant_q <= 1'b0; m1_grant_q <= 1'b1;
          end else if (bus.m0_req) begin
            state <= M0_GNT; m0_grant_q <= 1'b1; m1_grant_q <= 1'b0;
          end else begin
            state <= IDLE;   m0_grant_q <= 1'b0; m1_grant_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE; m0_grant_q <= 1'b0; m1_grant_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m0_grant = m0_grant_q;
  assign bus.m1_grant = m1_grant_q;

  // Forward the granted master's request fields; drive zeros when nobody owns the bus
  always_comb begin
    bus.m_req  = 1'b0;
    bus.m_wr   = 1'b0;
    bus.m_addr = {ADDR_W{1'b0}};
    bus.m_dout = {DATA_W{1'b0}};
    if (m0_grant_q) begin
      bus.m_req  = bus.m0_req;
      bus.m_wr   = bus.m0_wr;
      bus.m_addr = bus.m0_addr;
      bus.m_dout = bus.m0_dout;
    end else if (m1_grant_q) begin
      bus.m_req  = bus.m1_req;
      bus.m_wr   = bus.m1_wr;
      bus.m_addr = bus.m1_addr;
      bus.m_dout = bus.m1_dout;
    end
  end

  // Remember which slave was addressed so its synchronous read data is steered back next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= 2'b00;
    end else begin
      sel_q <= {bus.s1_sel, bus.s0_sel};
    end
  end

  // Read return mux; RAM wins if both selects were (illegally) set, unmapped reads return 0
  always_comb begin
    bus.m_din = {DATA_W{1'b0}};
    if (sel_q[0]) begin
      bus.m_din = bus.s0_dout;
    end else if (sel_q[1]) begin
      bus.m_din = bus.s1_dout;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a behavioural owner/slave model checked every cycle.
// Inputs change 1 time unit after the rising edge; the model is compared on the falling edge.
// Literal checks at key points pin the model to hand-computed values.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  bus_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  bus_arbiter #(.ADDR_W(16), .DATA_W(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is 0 (nobody), 1 (M0) or 2 (M1); last_slave is 0 (none), 1 (RAM) or 2 (core)
  int owner = 0;
  int last_slave = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner = 0;
      last_slave = 0;
    end else begin
      if ((owner == 1 && bus.m0_req) || (owner == 2 && bus.m1_req)) owner = owner;
      else if (bus.m0_req) owner = 1;
      else if (bus.m1_req) owner = 2;
      else owner = 0;
      last_slave = bus.s0_sel ? 1 : (bus.s1_sel ? 2 : 0);
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    check("m0_grant", bus.m0_grant, (owner == 1) ? 64'd1 : 64'd0);
    check("m1_grant", bus.m1_grant, (owner == 2) ? 64'd1 : 64'd0);
    check("m_req",  bus.m_req,  owner == 1 ? bus.m0_req  : owner == 2 ? bus.m1_req  : 1'b0);
    check("m_wr",   bus.m_wr,   owner == 1 ? bus.m0_wr   : owner == 2 ? bus.m1_wr   : 1'b0);
    check("m_addr", bus.m_addr, owner == 1 ? bus.m0_addr : owner == 2 ? bus.m1_addr : 16'h0);
    check("m_dout", bus.m_dout, owner == 1 ? bus.m0_dout : owner == 2 ? bus.m1_dout : 32'h0);
    check("m_din",  bus.m_din,  last_slave == 1 ? bus.s0_dout : last_slave == 2 ? bus.s1_dout : 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.m0_req = 0; bus.m0_wr = 0; bus.m0_addr = '0; bus.m0_dout = '0;
    bus.m1_req = 0; bus.m1_wr = 0; bus.m1_addr = '0; bus.m1_dout = '0;
    bus.s0_sel = 0; bus.s1_sel = 0; bus.s0_dout = '0; bus.s1_dout = '0;
    #3;
    check("rst_m0_grant", bus.m0_grant, 0);
    check("rst_m1_grant", bus.m1_grant, 0);
    check("rst_m_req", bus.m_req, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_din", bus.m_din, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Simultaneous requests: M0 wins, then M1 takes over with no gap
    bus.m0_req = 1; bus.m0_addr = 16'h0010;
    bus.m1_req = 1; bus.m1_addr = 16'h7004;
    step();
    check("sim_m0_grant", bus.m0_grant, 1);
    check("sim_m1_grant", bus.m1_grant, 0);
    check("sim_m_addr", bus.m_addr, 16'h0010);
    bus.m0_req = 0;
    step();
    check("handover_m1_grant", bus.m1_grant, 1);
    check("handover_m0_grant", bus.m0_grant, 0);

    // Hold: M1 keeps the bus while M0 waits
    bus.m0_req = 1;
    step();
    check("hold1_m1_grant", bus.m1_grant, 1);
    step();
    check("hold2_m1_grant", bus.m1_grant, 1);
    check("hold2_m0_grant", bus.m0_grant, 0);
    bus.m1_req = 0;
    step();
    check("release_m0_grant", bus.m0_grant, 1);
    check("release_m1_grant", bus.m1_grant, 0);

    // RAM read by M0
    bus.m0_wr = 0; bus.m0_addr = 16'h0010; bus.s0_sel = 1;
    #1;
    check("ram_m_addr", bus.m_addr, 16'h0010);
    step();
    bus.s0_sel = 0; bus.s0_dout = 32'h0000_0078;
    #1;
    check("ram_m_din", bus.m_din, 32'h0000_0078);

    // Core read by M1
    bus.m0_req = 0; bus.m1_req = 1; bus.m1_wr = 0; bus.m1_addr = 16'h7004;
    step();
    check("core_m1_grant", bus.m1_grant, 1);
    bus.s1_sel = 1;
    step();
    bus.s1_sel = 0; bus.s1_dout = 32'h0000_0018;
    #1;
    check("core_m_din", bus.m_din, 32'h0000_0018);

    // Unmapped read returns 0 even with slave data present
    bus.m1_addr = 16'h1000; bus.s0_dout = 32'h0000_dead; bus.s1_dout = 32'h0000_beef;
    step();
    check("unmapped_m_din", bus.m_din, 32'h0);

    // Both selects: RAM has priority
    bus.s0_sel = 1; bus.s1_sel = 1;
    step();
    bus.s0_sel = 0; bus.s1_sel = 0;
    #1;
    check("both_sel_m_din", bus.m_din, 32'h0000_dead);

    // Write by M0
    bus.m1_req = 0; bus.m0_req = 1;
    step();
    bus.m0_wr = 1; bus.m0_addr = 16'h7000; bus.m0_dout = 32'd5;
    #1;
    check("wr_m_req", bus.m_req, 1);
    check("wr_m_wr", bus.m_wr, 1);
    check("wr_m_addr", bus.m_addr, 16'h7000);
    check("wr_m_dout", bus.m_dout, 32'd5);

    // Reset mid-grant with read data pending
    bus.m0_wr = 0; bus.m0_addr = 16'h0020; bus.s0_sel = 1; bus.s0_dout = 32'h0000_00aa;
    step();
    bus.s0_sel = 0;
    #1;
    check("pre_rst_m_din", bus.m_din, 32'h0000_00aa);
    check("pre_rst_m0_grant", bus.m0_grant, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_m0_grant", bus.m0_grant, 0);
    check("midrst_m1_grant", bus.m1_grant, 0);
    check("midrst_m_req", bus.m_req, 0);
    check("midrst_m_din", bus.m_din, 0);
    bus.m0_req = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_idle", bus.m0_grant, 0);
    bus.m0_req = 1;
    step();
    check("rereq_m0_grant", bus.m0_grant, 1);
    bus.m0_req = 0;
    step();
    check("final_idle_m0", bus.m0_grant, 0);
    check("final_idle_m1", bus.m1_grant, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
